mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Initiator-side SRAM access sequencer for the SLC-3 CPU.
- Converts a single-word read/write request from the datapath (MAR/MDR side) into an active-low SRAM strobe sequence (CE/UB/LB/OE/WE) with configurable wait states.
- Returns read data plus a one-cycle completion pulse.
- Sits between the datapath/ISDU and Mem2IO/test_memory, replacing hand-sequenced memory strobes in the ISDU.

Parameters:
- WAIT_CYCLES, 2, number of cycles the OE/WE strobe is held active; legal range 1..15.
- ADDR_W, 16, address width.
- DATA_W, 16, data width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- req  in  1  request; sampled only while busy=0.
- wr  in  1  1=write, 0=read; sampled with req.
- byte_en  in  2  [1]=upper byte, [0]=lower byte; sampled with req.
- addr  in  ADDR_W  word address; sampled with req.
- wdata  in  DATA_W  write data; sampled with req.
- busy  out  1  high from the cycle after acceptance until return to IDLE.
- done  out  1  one-cycle pulse at completion.
- rdata  out  DATA_W  last read data; held until the next read completes.
- err  out  1  sticky protocol error (see Optional Feature).
- Mem_ADDR  out  ADDR_W  SRAM address.
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  active-low SRAM strobes.
- Mem_Dout  out  DATA_W  write data to the bus.
- Mem_Dout_en  out  1  drive enable for Mem_Dout; the top level builds the tristate.
- Mem_Din  in  DATA_W  read data from the bus.

Behaviour:
- All outputs are registered or decoded from state only (Moore). No combinational path from req to the Mem_* outputs.
- Reset values:
  - state=IDLE.
  - Mem_CE/UB/LB/OE/WE=1.
  - Mem_Dout_en=0, Mem_ADDR=0, Mem_Dout=0.
  - rdata=0, busy=0, done=0, err=0.
- Acceptance: IDLE and req=1 and byte_en!=0 at edge E0. addr/wr/byte_en/wdata are latched at E0; the next state is SETUP.
- A request with byte_en==0 is ignored; the FSM stays in IDLE.
- SETUP (1 cycle):
  - Mem_CE=0; Mem_UB=~byte_en[1]; Mem_LB=~byte_en[0]; Mem_ADDR valid.
  - Read: Mem_OE=0.
  - Write: Mem_Dout_en=1; Mem_WE stays 1.
- ACCESS (WAIT_CYCLES cycles):
  - Read: CE/OE stay low.
  - Write: Mem_WE=0, data driven.
  - The counter loads WAIT_CYCLES-1 on entry and decrements each cycle; the FSM exits at 0.
  - Read: Mem_Din is captured into rdata on the exit edge.
- RECOVER (1 cycle):
  - All strobes=1, done=1.
  - Write: Mem_Dout_en stays 1 this cycle (data hold after the WE rising edge), then drops to 0.
  - Mem_ADDR holds its value.
  - The next state is IDLE.
- Latency: done is high in the (WAIT_CYCLES+2)th cycle after E0. Default: 4 cycles. The next request can be accepted the cycle after done.
- busy=1 in SETUP, ACCESS and RECOVER.
- req while busy is ignored and is not queued.
- Reset mid-operation: at the next edge, strobes go inactive, Mem_Dout_en=0, state=IDLE, rdata=0, and no done pulse is issued.
- UB/LB apply to reads and writes alike. On a single-byte read, rdata captures the full Mem_Din; the caller masks it.
- Counter width: $clog2(WAIT_CYCLES+1). No wrap-around is possible because the counter reloads on each ACCESS entry.

Optional Feature:
- Macro: MEM_PROTOCOL_CHECK_EN.
- Defined: err is set and held until Reset in either case:
  - req=1 while busy=1;
  - req=1 with byte_en==0 in IDLE.
- Defined: the offending request is still ignored.
- Undefined: err is tied to 0 and the checking logic is absent. Functional behaviour is otherwise identical.

Decomposition:
- Package slc3_mem_pkg:
  - state enum {IDLE, SETUP, ACCESS, RECOVER} as logic [1:0];
  - constants MEM_ADDR_W=16, MEM_DATA_W=16;
  - strobe-inactive constant (5'b11111 for CE,UB,LB,OE,WE).
- One sub-module is natural: mem_wait_timer (load/decrement/zero-flag counter parameterised by WAIT_CYCLES).

Test Plan:
- Read, WAIT_CYCLES=2:
  - Stimulus: memory holds 0x1234 at 0x0040; req, wr=0, byte_en=11, addr=0x0040.
  - Response: CE/OE low for exactly 3 cycles; done 4 cycles after accept; rdata=0x1234; busy then clears.
- Write followed by read:
  - Stimulus: write wdata=0xBEEF to 0x0005, byte_en=11; then read 0x0005.
  - Response: WE low for exactly 2 cycles; Mem_Dout_en high through RECOVER; readback 0xBEEF.
- Byte write:
  - Stimulus: byte_en=10, wdata=0xAB00 onto existing 0x1122.
  - Response: Mem_UB=0, Mem_LB=1 during the access; readback 0xAB22.
- Ignored requests:
  - Stimulus: req held high throughout a transaction; then req with byte_en=00 in IDLE.
  - Response: exactly one transaction completes; no strobes for byte_en=00; err=1 only with MEM_PROTOCOL_CHECK_EN.
- Reset mid-write:
  - Stimulus: Reset asserted in the first ACCESS cycle.
  - Response: next cycle WE=1, CE=1, Dout_en=0, busy=0; no done; memory word unchanged only if the WE cycle had not completed (check against the model).
- WAIT_CYCLES=1 and WAIT_CYCLES=15 builds:
  - Stimulus: back-to-back reads 0x0000/0xFFFF.
  - Response: done at cycles 3 and 17 respectively; rdata correct; second request accepted the cycle after done.

Source files
------------

// File: rtl/slc3_mem_pkg.sv
// rtl/slc3_mem_pkg.sv - shared types and constants for the SLC-3 SRAM access sequencer
package slc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RECOVER = 2'd3
  } mem_state_e;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;

  // Bit order {CE, UB, LB, OE, WE}; all strobes are active-low.
  localparam logic [4:0] STROBE_IDLE = 5'b11111;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - wait-state counter: loads WAIT_CYCLES-1, counts down, flags zero
module mem_wait_timer #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - SLC-3 single-word SRAM access sequencer with wait states
// Optional sticky protocol-error flag enabled by MEM_PROTOCOL_CHECK_EN.
module mem_access_ctrl
  import slc3_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        byte_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic [DATA_W-1:0] Mem_Dout,
  output logic              Mem_Dout_en,
  input  logic [DATA_W-1:0] Mem_Din
);

  mem_state_e        r_state;
  logic [4:0]        r_strobe;
  logic              r_wr;
  logic              r_busy;
  logic              r_done;
  logic              r_dout_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] r_rdata;
  logic              w_zero;

  mem_wait_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .i_clk  (Clk),
    .i_reset(Reset),
    .i_load (r_state == SETUP),
    .i_dec  (r_state == ACCESS),
    .o_zero (w_zero)
  );

  // Outputs are set on the edge that enters each state, so every pin is a flop.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_strobe  <= STROBE_IDLE;
      r_wr      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dout_en <= 1'b0;
      r_addr    <= '0;
      r_dout    <= '0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req && (byte_en != 2'b00)) begin
            r_state   <= SETUP;
            r_busy    <= 1'b1;
            r_wr      <= wr;
            r_addr    <= addr;
            r_dout    <= wdata;
            r_strobe  <= {1'b0, ~byte_en[1], ~byte_en[0], wr, 1'b1};
            r_dout_en <= wr;
          end
        end
        SETUP: begin
          r_state     <= ACCESS;
          r_strobe[0] <= ~r_wr;
        end
        ACCESS: begin
          if (w_zero) begin
            r_state  <= RECOVER;
            r_strobe <= STROBE_IDLE;
            r_done   <= 1'b1;
            if (!r_wr) begin
              r_rdata <= Mem_Din;
            end
          end
        end
        RECOVER: begin
          // Write data was held through this cycle past the WE rising edge.
          r_state   <= IDLE;
          r_done    <= 1'b0;
          r_busy    <= 1'b0;
          r_dout_en <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MEM_PROTOCOL_CHECK_EN
  logic r_err;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_err <= 1'b0;
    end else if (req && (r_busy || ((r_state == IDLE) && (byte_en == 2'b00)))) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign busy        = r_busy;
  assign done        = r_done;
  assign rdata       = r_rdata;
  assign Mem_ADDR    = r_addr;
  assign Mem_Dout    = r_dout;
  assign Mem_Dout_en = r_dout_en;
  assign {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE} = r_strobe;

endmodule
